// File: rtl/ftseg_scan_driver.sv
// Multiplexed 14-segment scan driver with frame-synchronous double buffering.
// Optional leading-zero blanking is enabled by defining FTSEG_LZ_BLANK_EN.
module ftseg_scan_driver #(
  parameter int NDIG     = 4,
  parameter int SCAN_DIV = 1000,
  parameter int DIV_W    = 10
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [4*NDIG-1:0]    bcd_in,
  input  logic                 load,
  output logic [14:0]          display,
  output logic [NDIG-1:0]      digit_sel,
  output logic                 frame_tick,
  output logic                 pending
);

  localparam int IDX_W = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NDIG - 1);
  localparam logic [14:0]      SEG_BLANK = 15'h7FFF;

  function automatic logic [14:0] seg_code(input logic [3:0] d);
    logic [14:0] c;
    case (d)
      4'd0:    c = 15'h01FF;
      4'd1:    c = 15'h7FDB;
      4'd2:    c = 15'h127F;
      4'd3:    c = 15'h067F;
      4'd4:    c = 15'h4C7F;
      4'd5:    c = 15'h247F;
      4'd6:    c = 15'h207F;
      4'd7:    c = 15'h0FFF;
      4'd8:    c = 15'h007F;
      4'd9:    c = 15'h047F;
      default: c = SEG_BLANK;
    endcase
    return c;
  endfunction

`ifdef FTSEG_LZ_BLANK_EN
  // A digit is blanked when it and every more significant digit are zero; digit 0 always shows.
  function automatic logic lz_blank(input logic [4*NDIG-1:0] v, input int i);
    logic b;
    b = (i != 0);
    for (int j = 0; j < NDIG; j++) begin
      if (j >= i && v[4*j +: 4] != 4'd0) b = 1'b0;
    end
    return b;
  endfunction
`endif

  logic [DIV_W-1:0]  div_q, div_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [4*NDIG-1:0] active_q, active_d;
  logic [4*NDIG-1:0] pend_data_q, pend_data_d;
  logic              pend_valid_q, pend_valid_d;
  logic [14:0]       display_q, display_d;
  logic [NDIG-1:0]   digit_sel_q, digit_sel_d;
  logic              frame_tick_q, frame_tick_d;
  logic              pending_q, pending_d;
  logic              adv, wrap, swap, blank;
  logic [3:0]        digit;

  always_comb begin
    adv   = (div_q == DIV_LAST);
    wrap  = adv && (idx_q == IDX_LAST);
    swap  = wrap && pend_valid_q;
    div_d = adv ? '0 : div_q + 1'b1;
    idx_d = idx_q;
    if (adv) idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;

    // A load coinciding with a swap lands in the buffer after the old data moved out.
    active_d     = swap ? pend_data_q : active_q;
    pend_data_d  = load ? bcd_in : pend_data_q;
    pend_valid_d = load | (pend_valid_q & ~swap);

    digit = active_d[4*int'(idx_d) +: 4];
`ifdef FTSEG_LZ_BLANK_EN
    blank = lz_blank(active_d, int'(idx_d));
`else
    blank = 1'b0;
`endif

    display_d   = display_q;
    digit_sel_d = digit_sel_q;
    if (adv) begin
      display_d   = blank ? SEG_BLANK : seg_code(digit);
      digit_sel_d = ~({{(NDIG-1){1'b0}}, 1'b1} << idx_d);
    end
    frame_tick_d = wrap;
    pending_d    = pend_valid_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q        <= '0;
      idx_q        <= '0;
      active_q     <= '1;
      pend_valid_q <= 1'b0;
      display_q    <= SEG_BLANK;
      digit_sel_q  <= ~{{(NDIG-1){1'b0}}, 1'b1};
      frame_tick_q <= 1'b0;
      pending_q    <= 1'b0;
    end else begin
      div_q        <= div_d;
      idx_q        <= idx_d;
      active_q     <= active_d;
      pend_valid_q <= pend_valid_d;
      display_q    <= display_d;
      digit_sel_q  <= digit_sel_d;
      frame_tick_q <= frame_tick_d;
      pending_q    <= pending_d;
    end
  end

  // Buffer contents are qualified by pend_valid, so they need no reset.
  always_ff @(posedge clk) begin
    pend_data_q <= pend_data_d;
  end

  assign display    = display_q;
  assign digit_sel  = digit_sel_q;
  assign frame_tick = frame_tick_q;
  assign pending    = pending_q;

endmodule

// File: tb/tb_ftseg_scan_driver.sv
// Randomized self-checking bench for ftseg_scan_driver (NDIG=4, SCAN_DIV=4).
module tb_ftseg_scan_driver;
  localparam int NDIG = 4;
  localparam int SCAN_DIV = 4;
  localparam int FRAME = NDIG * SCAN_DIV;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        load;
  logic [15:0] bcd_in;
  logic [14:0] display;
  logic [3:0]  digit_sel;
  logic        frame_tick;
  logic        pending;

  ftseg_scan_driver #(.NDIG(NDIG), .SCAN_DIV(SCAN_DIV), .DIV_W(2)) dut (
    .clk(clk), .rst_n(rst_n), .bcd_in(bcd_in), .load(load),
    .display(display), .digit_sel(digit_sel), .frame_tick(frame_tick), .pending(pending)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int fails  = 0;

  // Reference model: edge count since reset release plus the two buffers.
  int          n;
  logic [15:0] m_active, m_pend;
  logic        m_pvalid;
  logic [14:0] seg_tab [16];

  function automatic int cur_idx();
    return (n / SCAN_DIV) % NDIG;
  endfunction

  function automatic logic [14:0] exp_disp();
    int i = cur_idx();
    logic [3:0] d = 4'((m_active >> (4 * i)) & 16'hF);
`ifdef FTSEG_LZ_BLANK_EN
    if (i > 0 && (m_active >> (4 * i)) == 16'h0) return 15'h7FFF;
`endif
    return seg_tab[d];
  endfunction

  function automatic logic [20:0] exp_all();
    logic [3:0] sel = ~(4'b0001 << cur_idx());
    logic tick = (n > 0) && (n % FRAME == 0);
    return {exp_disp(), sel, tick, m_pvalid};
  endfunction

  task automatic model_reset();
    n = 0; m_active = 16'hFFFF; m_pvalid = 1'b0;
  endtask

  task automatic tick(input logic l, input logic [15:0] d);
    load = l; bcd_in = d;
    @(posedge clk);
    n++;
    if (n % FRAME == 0 && m_pvalid) begin
      m_active = m_pend; m_pvalid = 1'b0;
    end
    if (l) begin
      m_pend = d; m_pvalid = 1'b1;
    end
    #1;
    load = 1'b0;
  endtask

  task automatic test_reset();
    checks++;
    if ({display, digit_sel, frame_tick, pending} !== {15'h7FFF, 4'hE, 1'b0, 1'b0}) begin
      fails++;
      $display("FAIL reset_state got %h required %h", {display, digit_sel, frame_tick, pending},
               {15'h7FFF, 4'hE, 1'b0, 1'b0});
    end
  endtask

  task automatic test_idle_scan();
    for (int k = 0; k < 2 * FRAME + 3; k++) begin
      tick(1'b0, 16'h0);
      checks++;
      if ({display, digit_sel, frame_tick, pending} !== exp_all()) begin
        fails++;
        $display("FAIL idle_scan n=%0d got %h required %h", n, {display, digit_sel, frame_tick, pending}, exp_all());
      end
    end
  endtask

  task automatic test_load_mid();
    while (n % FRAME != 5) tick(1'b0, 16'h0);
    tick(1'b1, 16'h1234);
    checks++;
    if (pending !== 1'b1) begin
      fails++; $display("FAIL load_mid_pending got %b required 1", pending);
    end
    while (n % FRAME != 0) tick(1'b0, 16'h0);
    checks++;
    if ({display, digit_sel, pending} !== {15'h4C7F, 4'hE, 1'b0}) begin
      fails++;
      $display("FAIL load_mid_swap got %h/%h/%b required 4c7f/e/0", display, digit_sel, pending);
    end
    for (int k = 0; k < FRAME; k++) begin
      tick(1'b0, 16'h0);
      checks++;
      if ({display, digit_sel, frame_tick, pending} !== exp_all()) begin
        fails++;
        $display("FAIL load_mid_scan n=%0d got %h required %h", n, {display, digit_sel, frame_tick, pending}, exp_all());
      end
    end
  endtask

  task automatic test_last_wins();
    while (n % FRAME != 2) tick(1'b0, 16'h0);
    tick(1'b1, 16'h5678);
    while (n % FRAME != 9) tick(1'b0, 16'h0);
    tick(1'b1, 16'h9012);
    while (n % FRAME != 0) tick(1'b0, 16'h0);
    checks++;
    if (display !== 15'h127F) begin
      fails++; $display("FAIL last_wins got %h required 127f", display);
    end
    for (int k = 0; k < FRAME; k++) begin
      tick(1'b0, 16'h0);
      checks++;
      if ({display, digit_sel, frame_tick, pending} !== exp_all()) begin
        fails++;
        $display("FAIL last_wins_scan n=%0d got %h required %h", n, {display, digit_sel, frame_tick, pending}, exp_all());
      end
    end
  endtask

  task automatic test_load_on_wrap();
    while (n % FRAME != 6) tick(1'b0, 16'h0);
    tick(1'b1, 16'h1111);
    while (n % FRAME != FRAME - 1) tick(1'b0, 16'h0);
    tick(1'b1, 16'h2222);
    checks++;
    if ({display, pending} !== {15'h7FDB, 1'b1}) begin
      fails++; $display("FAIL wrap_load_swap got %h/%b required 7fdb/1", display, pending);
    end
    for (int k = 0; k < FRAME; k++) begin
      tick(1'b0, 16'h0);
      checks++;
      if ({display, digit_sel, frame_tick, pending} !== exp_all()) begin
        fails++;
        $display("FAIL wrap_load_scan n=%0d got %h required %h", n, {display, digit_sel, frame_tick, pending}, exp_all());
      end
    end
    checks++;
    if ({display, pending} !== {15'h127F, 1'b0}) begin
      fails++; $display("FAIL wrap_load_next got %h/%b required 127f/0", display, pending);
    end
  endtask

  task automatic test_lz();
    logic [15:0] vals [2];
    vals[0] = 16'h0070; vals[1] = 16'h0000;
    for (int v = 0; v < 2; v++) begin
      tick(1'b1, vals[v]);
      while (n % FRAME != 0) tick(1'b0, 16'h0);
      for (int k = 0; k < FRAME; k++) begin
        tick(1'b0, 16'h0);
        checks++;
        if ({display, digit_sel, frame_tick, pending} !== exp_all()) begin
          fails++;
          $display("FAIL lz_scan val=%h n=%0d got %h required %h", vals[v], n,
                   {display, digit_sel, frame_tick, pending}, exp_all());
        end
      end
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 600; k++) begin
      tick($urandom_range(0, 9) == 0, 16'($urandom));
      checks++;
      if ({display, digit_sel, frame_tick, pending} !== exp_all()) begin
        fails++;
        $display("FAIL random n=%0d got %h required %h", n, {display, digit_sel, frame_tick, pending}, exp_all());
      end
    end
  endtask

  task automatic test_async_reset();
    while (n % FRAME != 3) tick(1'b0, 16'h0);
    tick(1'b1, 16'h8888);
    tick(1'b0, 16'h0);
    tick(1'b0, 16'h0);
    rst_n = 1'b0;
    #1;
    checks++;
    if ({display, digit_sel, frame_tick, pending} !== {15'h7FFF, 4'hE, 1'b0, 1'b0}) begin
      fails++;
      $display("FAIL async_reset got %h required %h", {display, digit_sel, frame_tick, pending},
               {15'h7FFF, 4'hE, 1'b0, 1'b0});
    end
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    for (int k = 0; k < 3 * FRAME; k++) begin
      tick(1'b0, 16'h0);
      checks++;
      if ({display, digit_sel, frame_tick, pending} !== exp_all()) begin
        fails++;
        $display("FAIL post_reset n=%0d got %h required %h", n, {display, digit_sel, frame_tick, pending}, exp_all());
      end
    end
  endtask

  initial begin
    seg_tab[0] = 15'h01FF; seg_tab[1] = 15'h7FDB; seg_tab[2] = 15'h127F; seg_tab[3] = 15'h067F;
    seg_tab[4] = 15'h4C7F; seg_tab[5] = 15'h247F; seg_tab[6] = 15'h207F; seg_tab[7] = 15'h0FFF;
    seg_tab[8] = 15'h007F; seg_tab[9] = 15'h047F;
    for (int i = 10; i < 16; i++) seg_tab[i] = 15'h7FFF;
    m_pend = 16'h0;
    model_reset();
    rst_n = 1'b0; load = 1'b0; bcd_in = 16'h0;
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    @(negedge clk);
    rst_n = 1'b1;
    test_idle_scan();
    test_load_mid();
    test_last_wins();
    test_load_on_wrap();
    test_lz();
    test_random();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
